// File: rtl/dyn_shiftrow.sv
// Registered AES ShiftRows stage with per-block row rotations (forward or inverse)
// followed by a 2-entry output FIFO that keeps in_ready free of any out_ready path.
module dyn_shiftrow #(
  parameter int NB      = 4,
  parameter int SW      = $clog2(NB),
  parameter int DYNAMIC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [4*SW-1:0]   in_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [15:0]       blk_cnt
);

  localparam int W = 32 * NB;

  logic [W-1:0] perm;
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Column indices are SW bits wide, so the mod-NB wrap of c +/- s is free.
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [SW-1:0] s;
    assign s = (DYNAMIC != 0) ? in_shift[r*SW +: SW] : SW'(r);

    for (genvar c = 0; c < NB; c++) begin : g_col
      logic [SW-1:0] src;
      assign src = in_inv ? (SW'(c) - s) : (SW'(c) + s);
      assign perm[W-1-32*c-8*r -: 8] = in_data[W-1-32*int'(src)-8*r -: 8];
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      blk_cnt <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  // Storage needs no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= perm;
    end
  end

endmodule

// File: doc/dyn_shiftrow.md
# dyn_shiftrow

Parametrised, registered ShiftRows stage for the AES datapath with per-block dynamic row-shift amounts and selectable forward or inverse direction. It sits between SubBytes and the bit-permuted MixColumns stage. It accepts one state per valid/ready handshake, applies a key-derived cyclic rotation to each row, and buffers results in a 2-entry output FIFO so the round pipeline tolerates downstream stalls without losing data.

## Interface
- NB, 4: number of state columns; legal values 4 or 8; state width W = 32*NB bits.
- SW, $clog2(NB): width of one row-shift field (2 for NB=4, 3 for NB=8).
- DYNAMIC, 1: 1 = row shifts taken from in_shift; 0 = in_shift ignored and row r shifts by r (standard AES).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_data  input  W  state; column c = in_data[W-1-32c -: 32]; row r of column c = in_data[W-1-32c-8r -: 8].
- in_inv  input  1  0 = forward shift, 1 = inverse shift.
- in_shift  input  4*SW  row r shift amount = in_shift[r*SW +: SW].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts head when out_valid && out_ready.
- out_data  output  W  shifted state, same byte layout as in_data.
- blk_cnt  output  16  number of accepted input blocks, wraps modulo 2^16.

## Operation
- Permutation, with s_r = (DYNAMIC ? in_shift field r : r) mod NB:
  - Forward: out[r][c] = in[r][(c + s_r) mod NB].
  - Inverse: out[r][c] = in[r][(c - s_r) mod NB].
- The permutation is combinational on in_data, in_inv and in_shift, sampled in the accept cycle. The FIFO stores only the permuted state; inv and shift are not carried forward.
- The same in_shift with opposite in_inv values exactly reverses the permutation.
- s_r = 0 on all rows gives identity in both directions.
- Output FIFO: 2 entries, registered write pointer, read pointer and count (0..2).
- in_ready = (count != 2). It is derived from registered count only and has no combinational path from out_ready.
- out_valid = (count != 0). out_data = entry at the read pointer, driven from registers.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
  - Push only: count +1.
  - Pop only: count −1.
  - Both: count unchanged; write and read pointers both advance.
- Pointers are 1 bit and wrap 1→0.
- blk_cnt increments by 1 on every push and wraps from 0xFFFF to 0x0000.
- No error conditions exist: every SW-bit shift value is legal because NB is a power of two.

## Timing
- Reset (rst=1 at a clock edge):
  - count = 0, both pointers = 0, blk_cnt = 0.
  - Next cycle: out_valid = 0, in_ready = 1. out_data is undefined and must not be sampled while out_valid = 0.
- Reset mid-operation discards both FIFO entries. A handshake that coincides with rst=1 is neither stored nor counted.
- Latency: a block pushed at edge T is visible on out_data with out_valid = 1 after edge T (first-word fall-through is not provided; there is no same-cycle bypass).
- Throughput: 1 block per cycle while out_ready = 1 is held. Count settles at 1.
- Backpressure: with out_ready = 0, two blocks are accepted and in_ready falls to 0 in the cycle after the second push.
  - When full, a pop frees a slot and in_ready returns to 1 the next cycle. A full FIFO never accepts on the same edge it pops.
- Ordering is strict FIFO. out_data is stable while out_valid && !out_ready.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, blk_cnt = 0 in the cycle after release; nothing emerges.
- Forward: NB = 4, in_data = aabbccddeeff00112233445566778899, in_inv = 0, in_shift = 8'he4, out_ready = 1 → one cycle later out_data = aaff4499ee3388dd2277cc1166bb0055; blk_cnt = 1.
- Inverse: same in_data, in_inv = 1, in_shift = 8'he4 → out_data = aa774411eebb885522ffcc99663300dd. Feeding that result back with in_inv = 0 returns the original state.
- Identity and static mode: in_shift = 8'h00 → out_data = in_data. With DYNAMIC = 0 and in_shift = 8'h00 → forward result equals the Forward vector above.
- Backpressure: out_ready = 0, offer blocks A, B, C back-to-back → A and B accepted, in_ready = 0, C held. Then out_ready = 1 → A, B, C emerge in order with no loss or duplication; blk_cnt = 3.
- Streaming and wrap: 65,537 consecutive blocks with random in_shift/in_inv and random out_ready, checked against a reference model → every output matches, and blk_cnt reads 1 after the last push.
